// File: rtl/rom_cell_fetch.sv
// ---------------------------------------------------------------------------
// rom_cell_fetch
//   Block-RAM ROM plus a fetch FSM that returns one whole typed lisp cell
//   (tag word plus up to three payload words) per valid/ready request. The
//   evaluator issues a single request per cell instead of sequencing the
//   individual word reads itself.
//
//   Optional build macro: ROM_CELL_CACHE_EN
//     Adds a one-entry cache of the last good response. A request for the
//     cached address is answered without touching the ROM.
//
// Parameters
//   ADDR_WIDTH  ROM address width, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH  ROM word width (tag and payload words)
//   INIT_FILE   image name; the ROM content is the built-in boot image
//               holding the expression (+ 5 3) with its root cell at 'hE
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    cell fetch request
//   req_ready_o    block is idle and can accept a request
//   req_addr_i     cell base address (address of the tag word)
//   rsp_valid_o    response valid, held until rsp_ready_i
//   rsp_ready_i    consumer accepts the response
//   rsp_type_o     tag word found at the base address
//   rsp_payload_o  {word2, word1, word0}, word k = ROM[base+1+k], unused = 0
//   rsp_err_o      tag is not a known cell type
// ---------------------------------------------------------------------------

package lisp;
    localparam logic [7:0] NIL            = 8'h00;
    localparam logic [7:0] TYPE_NUMBER    = 8'h01;
    localparam logic [7:0] TYPE_CONS      = 8'h02;
    localparam logic [7:0] TYPE_FUNC_PRIM = 8'h03;
    localparam logic [7:0] TYPE_PRIM_ADD  = 8'h10;
endpackage

module rom_cell_fetch #(
    parameter int    ADDR_WIDTH = 8,
    parameter int    DATA_WIDTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_type_o,
    output logic [3*DATA_WIDTH-1:0] rsp_payload_o,
    output logic                    rsp_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TAG  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [DATA_WIDTH-1:0] TAG_NUMBER = DATA_WIDTH'(lisp::TYPE_NUMBER);
    localparam logic [DATA_WIDTH-1:0] TAG_CONS   = DATA_WIDTH'(lisp::TYPE_CONS);
    localparam logic [DATA_WIDTH-1:0] TAG_PRIM   = DATA_WIDTH'(lisp::TYPE_FUNC_PRIM);

    // Built-in boot image: (+ 5 3) as a list of cells.
    //   'h0 NUMBER 5        'h2 NUMBER 3        'h4 PRIM <add> NIL NIL
    //   'h8 CONS 'h2 NIL    'hB CONS 'h0 'h8    'hE CONS 'h4 'hB  (root)
    function automatic logic [DATA_WIDTH-1:0] boot_word(input int a);
        case (a)
            0, 2:       boot_word = TAG_NUMBER;
            1:          boot_word = DATA_WIDTH'(8'h05);
            3:          boot_word = DATA_WIDTH'(8'h03);
            4:          boot_word = TAG_PRIM;
            5:          boot_word = DATA_WIDTH'(lisp::TYPE_PRIM_ADD);
            6, 7, 10:   boot_word = DATA_WIDTH'(lisp::NIL);
            8, 11, 14:  boot_word = TAG_CONS;
            9:          boot_word = DATA_WIDTH'(8'h02);
            12:         boot_word = DATA_WIDTH'(8'h00);
            13:         boot_word = DATA_WIDTH'(8'h08);
            15:         boot_word = DATA_WIDTH'(8'h04);
            16:         boot_word = DATA_WIDTH'(8'h0B);
            default:    boot_word = '0;
        endcase
    endfunction

    (* rom_style = "block" *) logic [DATA_WIDTH-1:0] rom_mem [DEPTH];

    // ROM image load; the FPGA bitstream carries this as BRAM init content.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[ADDR_WIDTH'(i)] = boot_word(i);
        end
    end

    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic                          rom_en;
    logic [DATA_WIDTH-1:0]         rom_data_q;

    logic [1:0]                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [1:0]                    k_q, k_d;
    logic [1:0]                    len_q, len_d;
    logic [DATA_WIDTH-1:0]         type_q, type_d;
    logic                          err_q, err_d;
    logic [2:0][DATA_WIDTH-1:0]    word_q, word_d;

`ifdef ROM_CELL_CACHE_EN
    logic                          cache_valid_q;
    logic [ADDR_WIDTH-1:0]         cache_addr_q;
    logic [DATA_WIDTH-1:0]         cache_type_q;
    logic [2:0][DATA_WIDTH-1:0]    cache_payload_q;
    logic                          cache_hit;
    logic                          hit_q, hit_d;

    assign cache_hit = cache_valid_q && (cache_addr_q == req_addr_i);
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        k_d      = k_q;
        len_d    = len_q;
        type_d   = type_q;
        err_d    = err_q;
        word_d   = word_q;
        rom_addr = req_addr_i;
        rom_en   = 1'b1;
`ifdef ROM_CELL_CACHE_EN
        hit_d    = hit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    base_d  = req_addr_i;
                    word_d  = '0;
                    type_d  = '0;
                    err_d   = 1'b0;
                    k_d     = 2'd0;
                    state_d = S_TAG;
`ifdef ROM_CELL_CACHE_EN
                    hit_d   = cache_hit;
                    rom_en  = !cache_hit;
`endif
                end
            end
            S_TAG: begin
                rom_addr = base_q + ADDR_WIDTH'(1);
                k_d      = 2'd0;
`ifdef ROM_CELL_CACHE_EN
                // A hit spends this cycle as a plain wait so its response
                // timing matches the shortest ROM path.
                if (hit_q) begin
                    rom_en  = 1'b0;
                    type_d  = cache_type_q;
                    word_d  = cache_payload_q;
                    state_d = S_RESP;
                end else
`endif
                begin
                    type_d  = rom_data_q;
                    state_d = S_PAY;
                    if (rom_data_q == TAG_NUMBER) begin
                        len_d = 2'd1;
                    end else if (rom_data_q == TAG_CONS) begin
                        len_d = 2'd2;
                    end else if (rom_data_q == TAG_PRIM) begin
                        len_d = 2'd3;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_PAY: begin
                // Prefetch the next payload word while latching this one.
                rom_addr     = base_q + ADDR_WIDTH'(2) + ADDR_WIDTH'(k_q);
                word_d[k_q]  = rom_data_q;
                if (k_q == len_q - 2'd1) begin
                    state_d = S_RESP;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_RESP: begin
                rom_addr = base_q;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rom_en) begin
            rom_data_q <= rom_mem[rom_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            k_q     <= '0;
            len_q   <= '0;
            type_q  <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            len_q   <= len_d;
            type_q  <= type_d;
            err_q   <= err_d;
            word_q  <= word_d;
        end
    end

`ifdef ROM_CELL_CACHE_EN
    // Refilled on every good response handshake; error responses never cached.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_valid_q   <= 1'b0;
            cache_addr_q    <= '0;
            cache_type_q    <= '0;
            cache_payload_q <= '0;
            hit_q           <= 1'b0;
        end else begin
            hit_q <= hit_d;
            if (state_q == S_RESP && rsp_ready_i && !err_q) begin
                cache_valid_q   <= 1'b1;
                cache_addr_q    <= base_q;
                cache_type_q    <= type_q;
                cache_payload_q <= word_q;
            end
        end
    end
`endif

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_type_o  = type_q;
    assign rsp_err_o   = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_payload
            assign rsp_payload_o[gi*DATA_WIDTH +: DATA_WIDTH] = word_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_rom_cell_fetch.sv
// ---------------------------------------------------------------------------
// tb_rom_cell_fetch
//   Self-checking bench for rom_cell_fetch (ADDR_WIDTH=8, DATA_WIDTH=8,
//   built-in boot image). Expected responses are queued when a request is
//   driven and popped when the DUT raises rsp_valid. Define
//   ROM_CELL_CACHE_EN for both files to exercise the cache build.
// ---------------------------------------------------------------------------
module tb_rom_cell_fetch;

    localparam logic [7:0] T_NUM  = 8'h01;
    localparam logic [7:0] T_CONS = 8'h02;
    localparam logic [7:0] T_PRIM = 8'h03;
    localparam logic [7:0] P_ADD  = 8'h10;
    localparam logic [7:0] NIL    = 8'h00;
`ifdef ROM_CELL_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_type;
    logic [23:0] rsp_payload;
    logic        rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  typ;
        logic [23:0] pay;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    // Reference model of the one-entry cache (only consulted in cache builds).
    logic       m_cache_valid = 1'b0;
    logic [7:0] m_cache_addr  = 8'h00;

    always #5 clk = ~clk;

    rom_cell_fetch #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .INIT_FILE  ("")
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_type_o    (rsp_type),
        .rsp_payload_o (rsp_payload),
        .rsp_err_o     (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_type"},      32'(rsp_type), 32'd0);
        check_eq({tag, "_payload"},   32'(rsp_payload), 32'd0);
        check_eq({tag, "_err"},       32'(rsp_err), 32'd0);
    endtask

    // One full transaction: drive request, wait (bounded) for the response,
    // compare against the queued expectation, optionally stall in RESP with
    // a spurious request asserted, then complete the handshake.
    task automatic fetch(input logic [7:0] addr, input logic [7:0] typ,
                         input logic [23:0] pay, input logic err,
                         input int full_lat, input int hold);
        exp_t e;
        int   lat;
        e.addr = addr;
        e.typ  = typ;
        e.pay  = pay;
        e.err  = err;
        e.lat  = (CACHE_EN && m_cache_valid && m_cache_addr == addr) ? 1 : full_lat;
        sb_q.push_back(e);

        check_eq("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 8'hA5;
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end

        e = sb_q.pop_front();
        check_eq("latency", 32'(lat), 32'(e.lat));
        check_eq("rsp_type", 32'(rsp_type), 32'(e.typ));
        check_eq("rsp_payload", 32'(rsp_payload), 32'(e.pay));
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        $display("txn addr=%02h type=%02h payload=%06h err=%0d lat=%0d",
                 e.addr, rsp_type, rsp_payload, rsp_err, lat);

        if (hold > 0) begin
            req_valid = 1'b1;
            req_addr  = 8'h00;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("hold_valid", 32'(rsp_valid), 32'd1);
                check_eq("hold_ready", 32'(req_ready), 32'd0);
                check_eq("hold_type", 32'(rsp_type), 32'(e.typ));
                check_eq("hold_payload", 32'(rsp_payload), 32'(e.pay));
            end
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_eq("post_hs_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_hs_ready", 32'(req_ready), 32'd1);
        if (hold > 0) begin
            @(negedge clk);
            check_eq("no_accept_ready", 32'(req_ready), 32'd1);
            check_eq("no_accept_valid", 32'(rsp_valid), 32'd0);
        end
        if (!err) begin
            m_cache_valid = 1'b1;
            m_cache_addr  = addr;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 8'h00;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Boot image cells
        fetch(8'h00, T_NUM,  24'h000005, 1'b0, 2, 0);
        fetch(8'h0E, T_CONS, {8'h00, 8'h0B, 8'h04}, 1'b0, 3, 0);
        fetch(8'h04, T_PRIM, {NIL, NIL, P_ADD}, 1'b0, 4, 0);
        fetch(8'h02, T_NUM,  24'h000003, 1'b0, 2, 0);
        fetch(8'h0B, T_CONS, {8'h00, 8'h08, 8'h00}, 1'b0, 3, 0);

        // Bench image at the top of the ROM: bad tag and a wrapping CONS
        dut.rom_mem[8'hFF] = 8'hFF;
        dut.rom_mem[8'hFE] = T_CONS;
        fetch(8'hFF, 8'hFF,  24'h000000, 1'b1, 1, 0);
        fetch(8'hFE, T_CONS, {8'h00, T_NUM, 8'hFF}, 1'b0, 3, 0);

        // Consumer stall in RESP with a spurious request asserted
        fetch(8'h08, T_CONS, {8'h00, NIL, 8'h02}, 1'b0, 3, 6);

        // Reset while in PAY of a CONS fetch
        req_valid = 1'b1;
        req_addr  = 8'h0E;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_fetch_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        m_cache_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        repeat (4) @(negedge clk);
        check_eq("abandoned_no_rsp", 32'(rsp_valid), 32'd0);
        fetch(8'h00, T_NUM, 24'h000005, 1'b0, 2, 0);

        // Repeated request (cache build answers the second one in 1 cycle)
        fetch(8'h0E, T_CONS, {8'h00, 8'h0B, 8'h04}, 1'b0, 3, 0);
        fetch(8'h0E, T_CONS, {8'h00, 8'h0B, 8'h04}, 1'b0, 3, 0);
        rst = 1'b1;
        m_cache_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch(8'h0E, T_CONS, {8'h00, 8'h0B, 8'h04}, 1'b0, 3, 0);

        check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
